// File: rtl/mul_div_unit_pkg.sv
// Shared RV32M decode constants, FSM encoding and special divide results.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_div_unit_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_FIN  = 2'd3
    } mdu_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring shift-subtract step of an unsigned divider.
// Latency: combinational.
// Backpressure: none; the caller iterates it once per cycle.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quot
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // quot carries the not-yet-consumed dividend bits in its upper part
    always_comb begin
        shifted   = {rem, quot[XLEN-1]};
        diff      = shifted - {1'b0, divisor};
        next_quot = {quot[XLEN-2:0], ~diff[XLEN]};
        next_rem  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit for the EX stage, stalling the pipe via BUSY.
// Latency: mul family 2 cycles, divide 33 cycles, div-by-zero/overflow 1 cycle.
// Backpressure: HOLD freezes the result in FIN; FLUSH aborts to IDLE.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DIV_ITER = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    input  logic            HOLD,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int CW = $clog2(DIV_ITER);

    mdu_state_t        state;
    logic [1:0]        f3;
    logic [XLEN-1:0]   quot, rem, dvs;
    logic [CW-1:0]     cnt;
    logic              sgn_a, sgn_b, neg_q, neg_r;

    logic              accept;
    logic              sgn_div, div0, ovf;
    logic [XLEN-1:0]   special_res, abs_a, abs_b;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic [XLEN-1:0]   mul_res, div_res, nrem, nquot;

    assign accept = START & ~FLUSH & ~RST &
                    ((state == MDU_IDLE) | ((state == MDU_FIN) & ~HOLD));
    assign BUSY   = ~RST & ((state == MDU_MUL) | (state == MDU_DIV) | accept);

    // Issue-time decode of the divide special cases and operand magnitudes
    always_comb begin
        sgn_div     = ~FUNCT3[0];
        div0        = (RS2 == '0);
        ovf         = sgn_div & (RS1 == SIGNED_MIN) & (RS2 == DIV_BY_ZERO_Q);
        special_res = div0 ? (FUNCT3[1] ? RS1 : DIV_BY_ZERO_Q)
                           : (FUNCT3[1] ? '0  : SIGNED_MIN);
        abs_a       = (sgn_div & RS1[XLEN-1]) ? -RS1 : RS1;
        abs_b       = (sgn_div & RS2[XLEN-1]) ? -RS2 : RS2;
    end

    // Low 2*XLEN bits of the 33x33 signed product; extension does the signedness
    always_comb begin
        ext_a   = {{XLEN{sgn_a & quot[XLEN-1]}}, quot};
        ext_b   = {{XLEN{sgn_b & dvs[XLEN-1]}}, dvs};
        prod    = ext_a * ext_b;
        mul_res = (f3 == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    div_restoring_step #(.XLEN(XLEN)) u_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (dvs),
        .next_rem  (nrem),
        .next_quot (nquot)
    );

    assign div_res = f3[1] ? (neg_r ? -nrem : nrem) : (neg_q ? -nquot : nquot);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= MDU_IDLE;
            f3     <= '0;
            quot   <= '0;
            rem    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
        end else if (FLUSH) begin
            state <= MDU_IDLE;
            DONE  <= 1'b0;
        end else if (accept) begin
            f3    <= FUNCT3[1:0];
            sgn_a <= FUNCT3[0] ^ FUNCT3[1];
            sgn_b <= FUNCT3[0] & ~FUNCT3[1];
            neg_q <= sgn_div & (RS1[XLEN-1] ^ RS2[XLEN-1]);
            neg_r <= sgn_div & RS1[XLEN-1];
            DONE  <= 1'b0;
            if (!FUNCT3[2]) begin
                quot  <= RS1;
                dvs   <= RS2;
                state <= MDU_MUL;
            end else if (div0 | ovf) begin
                RESULT <= special_res;
                DONE   <= 1'b1;
                state  <= MDU_FIN;
            end else begin
                quot  <= abs_a;
                dvs   <= abs_b;
                rem   <= '0;
                cnt   <= CW'(DIV_ITER - 1);
                state <= MDU_DIV;
            end
        end else begin
            case (state)
                MDU_MUL: begin
                    RESULT <= mul_res;
                    DONE   <= 1'b1;
                    state  <= MDU_FIN;
                end
                MDU_DIV: begin
                    rem  <= nrem;
                    quot <= nquot;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        RESULT <= div_res;
                        DONE   <= 1'b1;
                        state  <= MDU_FIN;
                    end
                end
                MDU_FIN: begin
                    if (!HOLD) begin
                        DONE  <= 1'b0;
                        state <= MDU_IDLE;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit: latency, results, HOLD, FLUSH, RST.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, START, HOLD, FLUSH;
    logic [2:0]  FUNCT3;
    logic [31:0] RS1, RS2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mul_div_unit dut (
        .CLK(CLK), .RST(RST), .START(START), .FUNCT3(FUNCT3),
        .RS1(RS1), .RS2(RS2), .HOLD(HOLD), .FLUSH(FLUSH),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=result expected=queued entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, RESULT, e);
        end
    endtask

    // Issue in cycle 0, then check BUSY/DONE every cycle up to the expected DONE cycle
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        @(posedge CLK); #1;
        START = 1'b1; FUNCT3 = f; RS1 = a; RS2 = b;
        exp_q.push_back(exp);
        @(negedge CLK);
        chk({tag, "_busy_c0"}, BUSY, 1);
        @(posedge CLK); #1;
        START = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge CLK);
            if (c < lat) begin
                if (DONE !== 1'b0 || BUSY !== 1'b1) begin
                    chk({tag, "_early"}, {30'd0, BUSY, DONE}, 32'd2);
                end
            end else begin
                chk({tag, "_done"}, DONE, 1);
                chk({tag, "_busy_fin"}, BUSY, 0);
                chk_result({tag, "_result"});
            end
            if (c < lat) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    initial begin
        int dones;
        RST = 1'b1; START = 1'b1; FUNCT3 = F3_MUL; RS1 = 32'd5; RS2 = 32'd6;
        HOLD = 1'b0; FLUSH = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_result", RESULT, 0);
        @(posedge CLK); #1;
        RST = 1'b0; START = 1'b0;

        // Multiply family
        run_op("mul",    F3_MUL,    32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 2);
        run_op("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 2);
        run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 2);
        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 2);

        // Signed divide
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);

        // Special cases
        run_op("divu_by0", F3_DIVU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", F3_REMU, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);
        run_op("div_ovf",  F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // HOLD in FIN for 5 cycles, then back-to-back issue
        @(posedge CLK); #1;
        HOLD = 1'b1; START = 1'b1; FUNCT3 = F3_MUL; RS1 = 32'd3; RS2 = 32'd5;
        exp_q.push_back(32'd15);
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("hold_done_first", DONE, 1);
        chk_result("hold_result_first");
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("hold_done", DONE, 1);
            chk("hold_result", RESULT, 32'd15);
        end
        @(posedge CLK); #1;
        HOLD = 1'b0; START = 1'b1; FUNCT3 = F3_MUL; RS1 = 32'd7; RS2 = 32'd6;
        exp_q.push_back(32'd42);
        @(negedge CLK);
        chk("b2b_busy", BUSY, 1);
        chk("b2b_done_last", DONE, 1);
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        chk("b2b_done_c1", DONE, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("b2b_done_c2", DONE, 1);
        chk_result("b2b_result");

        // FLUSH in DIV cycle 10; START held high during DIV must be ignored
        @(posedge CLK); #1;
        START = 1'b1; FUNCT3 = F3_DIVU; RS1 = 32'd1000; RS2 = 32'd3;
        @(posedge CLK); #1;
        FUNCT3 = F3_MUL; RS1 = 32'd9; RS2 = 32'd9;
        for (int c = 2; c <= 10; c++) begin
            @(posedge CLK); #1;
        end
        FLUSH = 1'b1; START = 1'b0;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        @(negedge CLK);
        chk("flush_busy", BUSY, 0);
        chk("flush_done", DONE, 0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) dones++;
        end
        chk("flush_no_done", dones, 0);
        chk("flush_result_kept", RESULT, 32'd42);
        run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);

        // RST mid-DIV
        @(posedge CLK); #1;
        START = 1'b1; FUNCT3 = F3_DIV; RS1 = 32'd500; RS2 = 32'd9;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rstdiv_busy", BUSY, 0);
        chk("rstdiv_done", DONE, 0);
        chk("rstdiv_result", RESULT, 0);
        run_op("remu_after_rst", F3_REMU, 32'd100, 32'd7, 32'd2, 33);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
